// File: rtl/rblwe_decrypt_param.sv
// rtl/rblwe_decrypt_param.sv - RBLWE decryption m = decode(c1*r2 + c2) over Z_q[x]/(x^N+1)
// Optional macro RBLWE_SKIP_ZERO_EN: rows with r2[i]=0 take one cycle instead of N.
module rblwe_decrypt_param #(
    parameter int N             = 256,
    parameter int LOGQ          = 8,
    parameter int MIN_THRESHOLD = 64,
    parameter int MAX_THRESHOLD = 192
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] c1_in,
    input  logic [LOGQ-1:0] c2_in,
    input  logic            r2_in,
    input  logic            start,
    output logic            busy,
    output logic            msg_out,
    output logic            msg_valid,
    input  logic            msg_ready,
    output logic            msg_last,
    output logic            done
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0]   LAST  = IW'(N - 1);
    localparam logic [LOGQ-1:0] MIN_T = LOGQ'(MIN_THRESHOLD);
    localparam logic [LOGQ-1:0] MAX_T = LOGQ'(MAX_THRESHOLD);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, MULT, ADD_C2, OUT} state_t;
    state_t state_q, state_d;

    logic [LOGQ-1:0] c1_mem [N];
    logic [LOGQ-1:0] c2_mem [N];
    logic [N-1:0]    r2_mem;
    logic [LOGQ-1:0] acc [N];
    logic [IW-1:0]   row_q, col_q;
    logic            done_q;

    logic          accept_beat, msg_fire, col_last, row_last, row_skip, row_end, wrap;
    logic [IW:0]   sum_ij;
    logic [IW-1:0] tgt;

    assign accept_beat = in_valid && in_ready;
    assign msg_fire    = msg_valid && msg_ready;
    assign col_last    = (col_q == LAST);
    assign row_last    = (row_q == LAST);
`ifdef RBLWE_SKIP_ZERO_EN
    assign row_skip    = !r2_mem[row_q];
`else
    assign row_skip    = 1'b0;
`endif
    assign row_end     = row_skip || col_last;
    // Carry out of i+j marks the negacyclic wrap: x^N = -1, so the term is subtracted.
    assign sum_ij      = {1'b0, row_q} + {1'b0, col_q};
    assign wrap        = sum_ij[IW];
    assign tgt         = sum_ij[IW-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (accept_beat) state_d = LOAD;
            LOAD:       if (accept_beat && col_last) state_d = WAIT_START;
            WAIT_START: if (start) state_d = MULT;
            MULT:       if (row_end && row_last) state_d = ADD_C2;
            ADD_C2:     if (col_last) state_d = OUT;
            OUT:        if (msg_fire && col_last) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q == MULT) || (state_q == ADD_C2) || (state_q == OUT);
    assign msg_valid = (state_q == OUT);
    assign msg_last  = (state_q == OUT) && col_last;
    assign msg_out   = (state_q == OUT) && (acc[col_q] > MIN_T) && (acc[col_q] < MAX_T);
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (accept_beat) begin
            c1_mem[col_q] <= c1_in;
            c2_mem[col_q] <= c2_in;
            r2_mem[col_q] <= r2_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < N; k++) acc[k] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    if (accept_beat) col_q <= col_last ? '0 : col_q + 1'b1;
                end
                WAIT_START: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) acc[k] <= '0;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                MULT: begin
                    if (r2_mem[row_q])
                        acc[tgt] <= wrap ? acc[tgt] - c1_mem[col_q] : acc[tgt] + c1_mem[col_q];
                    if (row_end) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                ADD_C2: begin
                    acc[col_q] <= acc[col_q] + c2_mem[col_q];
                    col_q      <= col_q + 1'b1;
                end
                OUT: begin
                    if (msg_fire) begin
                        col_q <= col_q + 1'b1;
                        if (col_last) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
